draw_sprite: RTL

Parametrised ROM-to-framebuffer blitter and successor to the full-screen image drawers. It copies an IMG_W x IMG_H image from a synchronous colour ROM to the VGA adapter plot interface at a run-time origin. It adds:
- frame selection through a base address
- colour-key transparency
- screen-edge clipping
- a ROM latency parameter
- a begin/done handshake
Used for backgrounds (origin 0,0, full size) and for the player, enemy and bullet sprites.

---
 rtl/draw_sprite.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/draw_sprite.sv
// draw_sprite: ROM-to-framebuffer blitter with screen clipping,
// colour-key transparency, frame base address and ROM latency.
module draw_sprite #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOR_BITS  = 3,
  parameter int ADDR_BITS   = 15,
  parameter int ROM_LATENCY = 1,
  parameter int KEY_EN      = 0,
  parameter int KEY_COLOR   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  begin_draw,
  input  logic [X_BITS-1:0]     x_origin,
  input  logic [Y_BITS-1:0]     y_origin,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic [ADDR_BITS-1:0]  rom_addr,
  output logic [X_BITS-1:0]     x,
  output logic [Y_BITS-1:0]     y,
  output logic [COLOR_BITS-1:0] color,
  output logic                  drawEn,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int XS = X_BITS + 1;
  localparam int YS = Y_BITS + 1;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [LW-1:0] L_LAST = LW'(ROM_LATENCY - 1);
  localparam logic [XS-1:0] X_LIM  = XS'(SCREEN_W);
  localparam logic [YS-1:0] Y_LIM  = YS'(SCREEN_H);
  localparam logic [COLOR_BITS-1:0] KEY_C = COLOR_BITS'(KEY_COLOR);
  localparam bit KEY_ON = (KEY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_WAIT,
    S_PLOT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [X_BITS-1:0]     r_xo;
  logic [Y_BITS-1:0]     r_yo;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [LW-1:0]         r_lat;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [X_BITS-1:0]     r_x;
  logic [Y_BITS-1:0]     r_y;
  logic [COLOR_BITS-1:0] r_color;
  logic                  r_draw;
  logic                  r_busy;
  logic                  r_done;

  // One extra bit so an origin near the top wraps into clipping.
  logic [XS-1:0] w_xs;
  logic [YS-1:0] w_ys;
  logic          w_vis;

  assign w_xs  = {1'b0, r_xo} + XS'(r_col);
  assign w_ys  = {1'b0, r_yo} + YS'(r_row);
  assign w_vis = (w_xs < X_LIM) && (w_ys < Y_LIM) &&
                 !(KEY_ON && (rom_data == KEY_C));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_xo    <= '0;
      r_yo    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_lat   <= '0;
      r_addr  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_draw  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_draw <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (begin_draw) begin
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_xo    <= x_origin;
          r_yo    <= y_origin;
          r_addr  <= base_addr;
          r_col   <= '0;
          r_row   <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_lat   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat == L_LAST) begin
            r_color <= rom_data;
            r_x     <= w_xs[X_BITS-1:0];
            r_y     <= w_ys[Y_BITS-1:0];
            r_draw  <= w_vis;
            r_state <= S_PLOT;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        S_PLOT: begin
          r_addr <= r_addr + ADDR_BITS'(1);
          if (r_col != C_LAST) begin
            r_col   <= r_col + CW'(1);
            r_state <= S_FETCH;
          end else if (r_row != R_LAST) begin
            r_col   <= '0;
            r_row   <= r_row + RW'(1);
            r_state <= S_FETCH;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!begin_draw) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = r_addr;
  assign x        = r_x;
  assign y        = r_y;
  assign color    = r_color;
  assign drawEn   = r_draw;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
